// File: rtl/escalonador_elevador_pkg.sv
// Shared definitions for the SCAN elevator scheduler: floor width, FSM states,
// default timing constants and pending-mask search helpers.
package escalonador_elevador_pkg;

    localparam int unsigned FLOOR_W           = 4;
    localparam int unsigned MAX_FLOORS        = 16;
    localparam int unsigned DEF_TRAVEL_CYCLES = 100;
    localparam int unsigned DEF_DOOR_CYCLES   = 50;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECIDE,
        ST_MOVE_UP,
        ST_MOVE_DOWN,
        ST_DOOR_OPEN
    } estado_t;

    function automatic logic any_above(input logic [MAX_FLOORS-1:0] mask,
                                       input logic [FLOOR_W-1:0]    fl);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
            if (i > 32'(fl) && mask[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [MAX_FLOORS-1:0] mask,
                                       input logic [FLOOR_W-1:0]    fl);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
            if (i < 32'(fl) && mask[i]) r = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/escalonador_elevador_timer_ciclos.sv
// Loadable down-counter; done is high in the last cycle of a loaded interval.
module timer_ciclos #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == WIDTH'(1));

endmodule

// File: rtl/escalonador_elevador.sv
// Single-car SCAN elevator scheduler: latches calls, picks direction, times
// travel and door phases, and owns the current-floor register.
module escalonador_elevador
    import escalonador_elevador_pkg::*;
#(
    parameter int unsigned N_FLOORS      = 16,
    parameter int unsigned TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter int unsigned DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [N_FLOORS-1:0] call_req,
    output logic [FLOOR_W-1:0]  floor,
    output logic                motor_up,
    output logic                motor_down,
    output logic                door_open,
    output logic                dir_up,
    output logic [N_FLOORS-1:0] pending,
    output logic                arrived,
    output logic                busy
);

    localparam int unsigned TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYCLES);
    localparam logic [TW-1:0] DOOR_LD   = TW'(DOOR_CYCLES);

    estado_t               state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic [N_FLOORS-1:0]   pending_q, pending_d;
    logic                  dir_up_q, dir_up_d;
    logic                  motor_up_q, motor_up_d;
    logic                  motor_down_q, motor_down_d;
    logic                  door_open_q, door_open_d;
    logic                  arrived_q, arrived_d;
    logic                  busy_q, busy_d;

    logic [MAX_FLOORS-1:0] pend16, call16, served16;
    logic                  trav_load, trav_en, trav_done;
    logic                  door_load, door_en, door_done;

    timer_ciclos #(.WIDTH(TW)) u_travel_timer (
        .clock    (clock),
        .clear    (clear),
        .load     (trav_load),
        .load_val (TRAVEL_LD),
        .en       (trav_en),
        .done     (trav_done)
    );

    timer_ciclos #(.WIDTH(TW)) u_door_timer (
        .clock    (clock),
        .clear    (clear),
        .load     (door_load),
        .load_val (DOOR_LD),
        .en       (door_en),
        .done     (door_done)
    );

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_up_d  = dir_up_q;
        trav_load = 1'b0;
        trav_en   = 1'b0;
        door_load = 1'b0;
        door_en   = 1'b0;
        served16  = '0;
        pend16    = '0;
        pend16[N_FLOORS-1:0] = pending_q;
        call16    = '0;
        call16[N_FLOORS-1:0] = call_req;

        // A call for the floor whose door is open is absorbed as a door-timer restart.
        if (state_q == ST_DOOR_OPEN) call16[floor_q] = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend16 != '0) begin
                    if (pend16[floor_q]) begin
                        state_d   = ST_DOOR_OPEN;
                        door_load = 1'b1;
                    end else begin
                        state_d = ST_DECIDE;
                    end
                end
            end
            ST_DECIDE: begin
                state_d = ST_IDLE;
                if (dir_up_q) begin
                    if (any_above(pend16, floor_q)) begin
                        state_d   = ST_MOVE_UP;
                        trav_load = 1'b1;
                    end else if (any_below(pend16, floor_q)) begin
                        state_d   = ST_MOVE_DOWN;
                        dir_up_d  = 1'b0;
                        trav_load = 1'b1;
                    end
                end else begin
                    if (any_below(pend16, floor_q)) begin
                        state_d   = ST_MOVE_DOWN;
                        trav_load = 1'b1;
                    end else if (any_above(pend16, floor_q)) begin
                        state_d   = ST_MOVE_UP;
                        dir_up_d  = 1'b1;
                        trav_load = 1'b1;
                    end
                end
            end
            ST_MOVE_UP: begin
                trav_en = 1'b1;
                if (trav_done) begin
                    floor_d = floor_q + 4'd1;
                    if (pend16[floor_d]) begin
                        state_d   = ST_DOOR_OPEN;
                        door_load = 1'b1;
                    end else if (any_above(pend16, floor_d)) begin
                        trav_load = 1'b1;
                    end else begin
                        state_d = ST_DECIDE;
                    end
                end
            end
            ST_MOVE_DOWN: begin
                trav_en = 1'b1;
                if (trav_done) begin
                    floor_d = floor_q - 4'd1;
                    if (pend16[floor_d]) begin
                        state_d   = ST_DOOR_OPEN;
                        door_load = 1'b1;
                    end else if (any_below(pend16, floor_d)) begin
                        trav_load = 1'b1;
                    end else begin
                        state_d = ST_DECIDE;
                    end
                end
            end
            ST_DOOR_OPEN: begin
                door_en = 1'b1;
                if (call_req[floor_q[$clog2(N_FLOORS)-1:0]]) begin
                    door_load = 1'b1;
                end else if (door_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_DOOR_OPEN && state_q != ST_DOOR_OPEN) served16[floor_d] = 1'b1;

        pending_d    = (pending_q | call16[N_FLOORS-1:0]) & ~served16[N_FLOORS-1:0];
        motor_up_d   = (state_d == ST_MOVE_UP);
        motor_down_d = (state_d == ST_MOVE_DOWN);
        door_open_d  = (state_d == ST_DOOR_OPEN);
        busy_d       = (state_d != ST_IDLE);
        arrived_d    = (floor_d != floor_q);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q      <= ST_IDLE;
            floor_q      <= '0;
            pending_q    <= '0;
            dir_up_q     <= 1'b1;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_open_q  <= 1'b0;
            arrived_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            floor_q      <= floor_d;
            pending_q    <= pending_d;
            dir_up_q     <= dir_up_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            door_open_q  <= door_open_d;
            arrived_q    <= arrived_d;
            busy_q       <= busy_d;
        end
    end

    assign floor      = floor_q;
    assign motor_up   = motor_up_q;
    assign motor_down = motor_down_q;
    assign door_open  = door_open_q;
    assign dir_up     = dir_up_q;
    assign pending    = pending_q;
    assign arrived    = arrived_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_escalonador_elevador.sv
// Scoreboard bench for the SCAN elevator scheduler (8 floors, travel 3, door 4).
module tb_escalonador_elevador;

    localparam int NF = 8;

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic [NF-1:0] call_req = '0;
    logic [3:0]    floor;
    logic          motor_up, motor_down, door_open, dir_up, arrived, busy;
    logic [NF-1:0] pending;

    escalonador_elevador #(
        .N_FLOORS      (NF),
        .TRAVEL_CYCLES (3),
        .DOOR_CYCLES   (4)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .call_req   (call_req),
        .floor      (floor),
        .motor_up   (motor_up),
        .motor_down (motor_down),
        .door_open  (door_open),
        .dir_up     (dir_up),
        .pending    (pending),
        .arrived    (arrived),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit is_door;
        int fl;
        int len;
        int gap;
        bit dir;
    } ev_t;

    ev_t sb[$];
    int  compared   = 0;
    int  mismatched = 0;

    task automatic chk(input string nm, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic push_arr(input int f, input bit d, input int gap);
        ev_t e;
        e.is_door = 1'b0; e.fl = f; e.len = 0; e.gap = gap; e.dir = d;
        sb.push_back(e);
    endtask

    task automatic push_door(input int f, input int len);
        ev_t e;
        e.is_door = 1'b1; e.fl = f; e.len = len; e.gap = 0; e.dir = 1'b0;
        sb.push_back(e);
    endtask

    task automatic pulse_call(input logic [NF-1:0] v);
        @(posedge clock); #1;
        call_req = v;
        @(posedge clock); #1;
        call_req = '0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        for (n = 0; n < 2000; n++) begin
            @(negedge clock);
            if (sb.size() == 0 && !busy) break;
        end
        if (n == 2000) begin
            compared++;
            mismatched++;
            $display("FAIL %s: timeout with %0d events outstanding, busy=%0d", nm, sb.size(), busy);
            sb.delete();
        end
    endtask

    // Monitor: pops expected events on every arrival pulse and door closing.
    int  cyc = 0, last_arr = 0, door_len = 0;
    bit  prev_door = 0, prev_mu = 0, prev_md = 0;
    ev_t me;

    always @(negedge clock) begin
        cyc++;
        if (clear) begin
            door_len  = 0;
            prev_door = 0;
            prev_mu   = 0;
            prev_md   = 0;
        end else begin
            compared++;
            if ((motor_up && motor_down) || (door_open && (motor_up || motor_down)) || floor >= NF) begin
                mismatched++;
                $display("FAIL invariant: mu=%0d md=%0d door=%0d floor=%0d", motor_up, motor_down, door_open, floor);
            end
            if (arrived) begin
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL arrival: unexpected arrival at floor %0d", floor);
                end else begin
                    me = sb.pop_front();
                    if (me.is_door || me.fl != int'(floor) || dir_up != me.dir || prev_mu != me.dir ||
                        prev_md == me.dir || (me.gap != 0 && cyc - last_arr != me.gap)) begin
                        mismatched++;
                        $display("FAIL arrival: got floor=%0d dir_up=%0d mu=%0d md=%0d gap=%0d, expected door=%0d floor=%0d dir=%0d gap=%0d",
                                 floor, dir_up, prev_mu, prev_md, cyc - last_arr, me.is_door, me.fl, me.dir, me.gap);
                    end
                end
                last_arr = cyc;
            end
            if (door_open) begin
                door_len++;
            end else if (prev_door) begin
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL door: unexpected door at floor %0d len %0d", floor, door_len);
                end else begin
                    me = sb.pop_front();
                    if (!me.is_door || me.fl != int'(floor) || me.len != door_len) begin
                        mismatched++;
                        $display("FAIL door: got floor=%0d len=%0d, expected door=%0d floor=%0d len=%0d",
                                 floor, door_len, me.is_door, me.fl, me.len);
                    end
                end
                door_len = 0;
            end
            prev_door = door_open;
            prev_mu   = motor_up;
            prev_md   = motor_down;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_floor", floor, 0);
        chk("rst_pending", pending, 0);
        chk("rst_dir_up", dir_up, 1);
        chk("rst_outputs", {motor_up, motor_down, door_open, arrived, busy}, 0);
        clear = 1'b0;

        // Call at current floor: pending at t+1, door at t+2 for 4 cycles
        push_door(0, 4);
        @(posedge clock); #1;
        call_req = 8'h01;
        @(posedge clock); #1;
        call_req = '0;
        chk("t2_pending_t1", pending, 8'h01);
        chk("t2_door_t1", door_open, 0);
        @(posedge clock); #1;
        chk("t2_door_t2", door_open, 1);
        chk("t2_pending_t2", pending, 0);
        wait_idle("t2_done");
        chk("t2_pending_end", pending, 0);

        // Floor 0 -> 5, arrivals 3 cycles apart
        push_arr(1, 1, 0);
        for (int f = 2; f <= 5; f++) push_arr(f, 1, 3);
        push_door(5, 4);
        pulse_call(8'h20);
        wait_idle("t3_done");
        chk("t3_floor", floor, 5);

        // Floor 5 -> 3, then door reopen by a call to 3 during door cycle 3
        push_arr(4, 0, 0);
        push_arr(3, 0, 3);
        push_door(3, 7);
        pulse_call(8'h08);
        for (n = 0; n < 200; n++) begin
            @(negedge clock);
            if (door_open) break;
        end
        chk("t5_door_seen", door_open, 1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        call_req = 8'h08;
        @(posedge clock); #1;
        call_req = '0;
        chk("t5_pending_not_latched", pending, 0);
        chk("t5_door_still_open", door_open, 1);
        wait_idle("t5_done");

        // SCAN: go to 2, then up toward 6 with calls to 4 and 1 en route
        push_arr(2, 0, 0);
        push_door(2, 4);
        pulse_call(8'h04);
        wait_idle("t4_setup");
        push_arr(3, 1, 0);
        push_arr(4, 1, 3);
        push_door(4, 4);
        push_arr(5, 1, 0);
        push_arr(6, 1, 3);
        push_door(6, 4);
        push_arr(5, 0, 0);
        for (int f = 4; f >= 1; f--) push_arr(f, 0, 3);
        push_door(1, 4);
        pulse_call(8'h40);
        pulse_call(8'h10);
        pulse_call(8'h02);
        wait_idle("t4_done");
        chk("t4_floor", floor, 1);
        chk("t4_dir_up", dir_up, 0);

        // Clear mid-move at floor 3
        push_arr(2, 1, 0);
        push_arr(3, 1, 3);
        pulse_call(8'h40);
        for (n = 0; n < 200; n++) begin
            @(negedge clock);
            if (floor == 4'd3) break;
        end
        @(posedge clock); #2;
        chk("t1_moving", motor_up, 1);
        chk("t1_events_done", sb.size(), 0);
        sb.delete();
        clear = 1'b1;
        #1;
        chk("t1_floor", floor, 0);
        chk("t1_pending", pending, 0);
        chk("t1_dir_up", dir_up, 1);
        chk("t1_outputs", {motor_up, motor_down, door_open, arrived, busy}, 0);
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;

        // All floors called at floor 0
        push_door(0, 4);
        for (int f = 1; f < NF; f++) begin
            push_arr(f, 1, 0);
            push_door(f, 4);
        end
        pulse_call(8'hFF);
        wait_idle("t6_done");
        chk("t6_floor", floor, 7);
        chk("t6_pending", pending, 0);
        chk("t6_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
